// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: datapath widths, mem_op encodings, FSM states, EX packet.
// Pure declarations; no timing or flow-control behaviour lives here.
package mem_stage_pkg;

  localparam int XLEN   = 64;
  localparam int BUS_W  = XLEN;
  localparam int STRB_W = BUS_W / 8;

  typedef enum logic [2:0] {
    MOP_B  = 3'b000,
    MOP_H  = 3'b001,
    MOP_W  = 3'b010,
    MOP_D  = 3'b011,
    MOP_BU = 3'b100,
    MOP_HU = 3'b101,
    MOP_WU = 3'b110,
    MOP_DX = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic            wren;
    logic [2:0]      op;
  } ex_pkt_t;

  // log2 of the access size in bytes; 111 aliases the doubleword code
  function automatic logic [1:0] op_size(logic [2:0] op);
    return (op == MOP_DX) ? 2'd3 : op[1:0];
  endfunction

  function automatic logic op_signed(logic [2:0] op);
    return !op[2] || (op == MOP_DX);
  endfunction

  function automatic logic op_misaligned(logic [2:0] op, logic [2:0] off);
    logic [2:0] m;
    case (op_size(op))
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return (off & m) != 3'b000;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Handshake bundles around the MEM stage: EX->MEM, MEM<->data memory, MEM->WB.
// Plain valid/ready; each interface has master (producer) and slave (consumer) views.
interface ex_mem_if;
  import mem_stage_pkg::*;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] PC_mem_i;
  logic [XLEN-1:0] instr_mem_i;
  logic [XLEN-1:0] alures_i;
  logic [XLEN-1:0] rs2_mem_i;
  logic            mem_wren_i;
  logic            mem_lden_i;
  logic [2:0]      mem_op_i;

  modport master (output in_valid, PC_mem_i, instr_mem_i, alures_i, rs2_mem_i,
                         mem_wren_i, mem_lden_i, mem_op_i,
                  input  in_ready);
  modport slave  (input  in_valid, PC_mem_i, instr_mem_i, alures_i, rs2_mem_i,
                         mem_wren_i, mem_lden_i, mem_op_i,
                  output in_ready);
endinterface

interface mem_req_if;
  import mem_stage_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              req_wen;
  logic [BUS_W-1:0]  req_wdata;
  logic [STRB_W-1:0] req_wmask;
  logic              resp_valid;
  logic [BUS_W-1:0]  resp_rdata;

  modport master (output req_valid, req_addr, req_wen, req_wdata, req_wmask,
                  input  req_ready, resp_valid, resp_rdata);
  modport slave  (input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
                  output req_ready, resp_valid, resp_rdata);
endinterface

interface mem_wb_if;
  import mem_stage_pkg::*;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] PC_mem_o;
  logic [XLEN-1:0] instr_mem_o;
  logic [XLEN-1:0] wbdata_o;
  logic            misalign_o;

  modport master (output out_valid, PC_mem_o, instr_mem_o, wbdata_o, misalign_o,
                  input  out_ready);
  modport slave  (input  out_valid, PC_mem_o, instr_mem_o, wbdata_o, misalign_o,
                  output out_ready);
endinterface

// File: rtl/mem_stage_align.sv
// mem_align: combinational store lane/strobe generation and load extract/extension.
// Zero latency; no flow control. Accesses crossing the 8-byte line are truncated to it.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [2:0]        off,
  input  logic              wren,
  input  logic [XLEN-1:0]   st_data,
  input  logic [BUS_W-1:0]  rdata,
  output logic [BUS_W-1:0]  wdata,
  output logic [STRB_W-1:0] wmask,
  output logic [XLEN-1:0]   ldata
);

  logic [5:0]        sh_amt;
  logic              sgn;
  logic [BUS_W-1:0]  rsh;
  logic [STRB_W-1:0] size_mask;

  assign sh_amt = {off, 3'b000};
  assign sgn    = op_signed(op);
  assign rsh    = rdata >> sh_amt;

  always_comb begin
    size_mask = '0;
    ldata     = '0;
    case (op_size(op))
      2'd0: begin
        size_mask = 8'h01;
        ldata     = {{(XLEN-8){sgn & rsh[7]}}, rsh[7:0]};
      end
      2'd1: begin
        size_mask = 8'h03;
        ldata     = {{(XLEN-16){sgn & rsh[15]}}, rsh[15:0]};
      end
      2'd2: begin
        size_mask = 8'h0F;
        ldata     = {{(XLEN-32){sgn & rsh[31]}}, rsh[31:0]};
      end
      default: begin
        size_mask = 8'hFF;
        ldata     = rsh;
      end
    endcase
    // bits shifted past the top of the line are simply dropped
    wmask = wren ? (size_mask << off) : '0;
    wdata = wren ? (st_data << sh_amt) : '0;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues one load/store per accepted EX result, 1 cycle for ALU ops, >=3 for memory.
// in_ready low while a request is outstanding or WB stalls; MEM_MISALIGN_CHK_EN traps misaligned accesses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  ex_mem_if.slave   ex,
  mem_req_if.master mem,
  mem_wb_if.master  wb
);

`ifdef MEM_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  ex_pkt_t         pkt_q, pkt_d;
  logic            out_valid_q, out_valid_d;
  logic            req_valid_q, req_valid_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] wbdata_q, wbdata_d;

  logic              accept;
  logic              in_is_mem;
  logic [BUS_W-1:0]  st_wdata;
  logic [STRB_W-1:0] st_wmask;
  logic [XLEN-1:0]   ld_data;

  assign ex.in_ready = (state_q == ST_IDLE) && (!out_valid_q || wb.out_ready);
  assign accept      = ex.in_valid && ex.in_ready;
  assign in_is_mem   = ex.mem_wren_i || ex.mem_lden_i;

  // Aligner works off the latched packet so request fields stay stable during REQ
  mem_align u_align (
    .op      (pkt_q.op),
    .off     (pkt_q.addr[2:0]),
    .wren    (pkt_q.wren),
    .st_data (pkt_q.data),
    .rdata   (mem.resp_rdata),
    .wdata   (st_wdata),
    .wmask   (st_wmask),
    .ldata   (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    out_valid_d = out_valid_q && !wb.out_ready;
    req_valid_d = req_valid_q;
    misalign_d  = misalign_q;
    wbdata_d    = wbdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pkt_d = '{pc:    ex.PC_mem_i,
                    instr: ex.instr_mem_i,
                    addr:  ex.alures_i,
                    data:  ex.rs2_mem_i,
                    wren:  ex.mem_wren_i,
                    op:    ex.mem_op_i};
          if (!in_is_mem) begin
            out_valid_d = 1'b1;
            wbdata_d    = ex.alures_i;
            misalign_d  = 1'b0;
          end else if (CHK_EN && op_misaligned(ex.mem_op_i, ex.alures_i[2:0])) begin
            out_valid_d = 1'b1;
            wbdata_d    = '0;
            misalign_d  = 1'b1;
          end else begin
            state_d     = ST_REQ;
            req_valid_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (mem.req_ready) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (mem.resp_valid) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          wbdata_d    = pkt_q.wren ? '0 : ld_data;
          misalign_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pkt_q       <= '0;
      out_valid_q <= 1'b0;
      req_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      wbdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      out_valid_q <= out_valid_d;
      req_valid_q <= req_valid_d;
      misalign_q  <= misalign_d;
      wbdata_q    <= wbdata_d;
    end
  end

  assign mem.req_valid = req_valid_q;
  assign mem.req_addr  = {pkt_q.addr[XLEN-1:3], 3'b000};
  assign mem.req_wen   = pkt_q.wren;
  assign mem.req_wdata = st_wdata;
  assign mem.req_wmask = st_wmask;

  assign wb.out_valid   = out_valid_q;
  assign wb.PC_mem_o    = pkt_q.pc;
  assign wb.instr_mem_o = pkt_q.instr;
  assign wb.wbdata_o    = wbdata_q;
  assign wb.misalign_o  = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed timing checks plus a WB-side scoreboard.
// Define MEM_MISALIGN_CHK_EN consistently for RTL and bench to exercise the trap path.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_if  ex_if();
  mem_req_if mem_if();
  mem_wb_if  wb_if();

  mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex_if),
    .mem   (mem_if),
    .wb    (wb_if)
  );

  typedef struct {
    logic [63:0] pc;
    logic [63:0] wb;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  op;
    logic        wren;
    logic        lden;
    logic [63:0] rs2;
    logic [63:0] rd;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int op_bytes(logic [2:0] op);
    if (op == 3'b111) return 8;
    return 1 << op[1:0];
  endfunction

  // Reference load: gather bytes from the line (dropping ones past byte 7), then extend
  function automatic logic [63:0] exp_load(logic [63:0] rd, logic [2:0] op, logic [2:0] off);
    logic [63:0] v  = '0;
    int          nb = op_bytes(op);
    for (int i = 0; i < nb; i++)
      if (int'(off) + i < 8) v[8*i +: 8] = rd[8*(int'(off) + i) +: 8];
    if ((!op[2] || op == 3'b111) && nb < 8 && v[8*nb-1])
      for (int b = 8*nb; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] exp_mask(logic [2:0] op, logic [2:0] off);
    logic [7:0] m  = '0;
    int         nb = op_bytes(op);
    for (int i = 0; i < nb; i++)
      if (int'(off) + i < 8) m[int'(off) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] exp_wdata(logic [63:0] rs2, logic [2:0] off);
    logic [63:0] w = '0;
    for (int b = 0; b < 8; b++)
      if (b >= int'(off)) w[8*b +: 8] = rs2[8*(b - int'(off)) +: 8];
    return w;
  endfunction

  task automatic add_vec(logic [63:0] addr, logic [2:0] op, logic wren, logic lden,
                         logic [63:0] rs2, logic [63:0] rd);
    vec_t v;
    v.addr = addr; v.op = op; v.wren = wren; v.lden = lden; v.rs2 = rs2; v.rd = rd;
    vecs.push_back(v);
  endtask

  task automatic push_exp(logic [63:0] pc, logic [63:0] wbv, logic mis);
    exp_t e;
    e.pc = pc; e.wb = wbv; e.mis = mis;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic issue(logic [63:0] pc, logic [63:0] alu, logic [63:0] rs2,
                       logic wren, logic lden, logic [2:0] op);
    int k = 0;
    ex_if.PC_mem_i    = pc;
    ex_if.instr_mem_i = pc ^ 64'h13;
    ex_if.alures_i    = alu;
    ex_if.rs2_mem_i   = rs2;
    ex_if.mem_wren_i  = wren;
    ex_if.mem_lden_i  = lden;
    ex_if.mem_op_i    = op;
    ex_if.in_valid    = 1'b1;
    while (!ex_if.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("in_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    ex_if.in_valid = 1'b0;
  endtask

  task automatic serve(logic [63:0] rd, int gap);
    int k = 0;
    while (!mem_if.req_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("req_timeout", 64'd0, 64'd1);
    repeat (gap) @(negedge clk);
    mem_if.req_ready = 1'b1;
    @(negedge clk);
    mem_if.req_ready  = 1'b0;
    mem_if.resp_valid = 1'b1;
    mem_if.resp_rdata = rd;
    @(negedge clk);
    mem_if.resp_valid = 1'b0;
  endtask

  // Scoreboard: sample just after the negedge so stimulus for the coming edge has settled
  always @(negedge clk) begin
    #1;
    if (rst_n && wb_if.out_valid && wb_if.out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", 64'd1, 64'd0);
      end else begin
        check("sb_pc", wb_if.PC_mem_o, sb_q[0].pc);
        check("sb_instr", wb_if.instr_mem_o, sb_q[0].pc ^ 64'h13);
        check("sb_wbdata", wb_if.wbdata_o, sb_q[0].wb);
        check("sb_misalign", {63'd0, wb_if.misalign_o}, {63'd0, sb_q[0].mis});
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    ex_if.in_valid    = 1'b0;
    ex_if.PC_mem_i    = '0;
    ex_if.instr_mem_i = '0;
    ex_if.alures_i    = '0;
    ex_if.rs2_mem_i   = '0;
    ex_if.mem_wren_i  = 1'b0;
    ex_if.mem_lden_i  = 1'b0;
    ex_if.mem_op_i    = '0;
    mem_if.req_ready  = 1'b0;
    mem_if.resp_valid = 1'b0;
    mem_if.resp_rdata = '0;
    wb_if.out_ready   = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, wb_if.out_valid}, 64'd0);
    check("rst_req_valid", {63'd0, mem_if.req_valid}, 64'd0);
    check("rst_req_wen", {63'd0, mem_if.req_wen}, 64'd0);
    check("rst_misalign", {63'd0, wb_if.misalign_o}, 64'd0);
    check("rst_wbdata", wb_if.wbdata_o, 64'd0);
    check("rst_pc_o", wb_if.PC_mem_o, 64'd0);
    check("rst_req_addr", mem_if.req_addr, 64'd0);
    check("rst_req_wmask", {56'd0, mem_if.req_wmask}, 64'd0);
    check("rst_req_wdata", mem_if.req_wdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {63'd0, ex_if.in_ready}, 64'd1);

    // ALU-only result appears one cycle after accept
    push_exp(64'h100, 64'h1234, 1'b0);
    issue(64'h100, 64'h1234, 64'h55, 1'b0, 1'b0, 3'b011);
    check("nm_out_valid", {63'd0, wb_if.out_valid}, 64'd1);
    check("nm_wbdata", wb_if.wbdata_o, 64'h1234);
    check("nm_req_valid", {63'd0, mem_if.req_valid}, 64'd0);
    @(negedge clk);
    check("nm_req_valid_later", {63'd0, mem_if.req_valid}, 64'd0);

    // SW with request and WB backpressure
    push_exp(64'h104, 64'd0, 1'b0);
    issue(64'h104, 64'h8000_0004, 64'hDEAD_BEEF, 1'b1, 1'b0, 3'b010);
    for (int c = 0; c < 3; c++) begin
      check("sw_req_valid", {63'd0, mem_if.req_valid}, 64'd1);
      check("sw_req_addr", mem_if.req_addr, 64'h8000_0000);
      check("sw_req_wmask", {56'd0, mem_if.req_wmask}, 64'hF0);
      check("sw_req_wdata", mem_if.req_wdata, 64'hDEAD_BEEF_0000_0000);
      check("sw_req_wen", {63'd0, mem_if.req_wen}, 64'd1);
      check("sw_in_ready", {63'd0, ex_if.in_ready}, 64'd0);
      @(negedge clk);
    end
    wb_if.out_ready  = 1'b0;
    mem_if.req_ready = 1'b1;
    @(negedge clk);
    mem_if.req_ready = 1'b0;
    check("sw_req_drop", {63'd0, mem_if.req_valid}, 64'd0);
    check("sw_wait_no_out", {63'd0, wb_if.out_valid}, 64'd0);
    check("sw_wait_in_ready", {63'd0, ex_if.in_ready}, 64'd0);
    mem_if.resp_valid = 1'b1;
    mem_if.resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_if.resp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("sw_hold_out_valid", {63'd0, wb_if.out_valid}, 64'd1);
      check("sw_hold_wbdata", wb_if.wbdata_o, 64'd0);
      check("sw_hold_pc", wb_if.PC_mem_o, 64'h104);
      check("sw_hold_in_ready", {63'd0, ex_if.in_ready}, 64'd0);
      @(negedge clk);
    end
    wb_if.out_ready = 1'b1;
    @(negedge clk);

    // LB at byte 7 with minimum latency: result visible three edges after accept
    push_exp(64'h108, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    issue(64'h108, 64'h8000_1007, 64'd0, 1'b0, 1'b1, 3'b000);
    check("lb_req_valid", {63'd0, mem_if.req_valid}, 64'd1);
    check("lb_req_addr", mem_if.req_addr, 64'h8000_1000);
    check("lb_req_wen", {63'd0, mem_if.req_wen}, 64'd0);
    mem_if.req_ready = 1'b1;
    @(negedge clk);
    mem_if.req_ready = 1'b0;
    check("lb_req_drop", {63'd0, mem_if.req_valid}, 64'd0);
    check("lb_out_early", {63'd0, wb_if.out_valid}, 64'd0);
    mem_if.resp_valid = 1'b1;
    mem_if.resp_rdata = 64'h8012_3456_789A_BCDE;
    @(negedge clk);
    mem_if.resp_valid = 1'b0;
    check("lb_out_valid", {63'd0, wb_if.out_valid}, 64'd1);
    check("lb_wbdata", wb_if.wbdata_o, 64'hFFFF_FFFF_FFFF_FF80);

    push_exp(64'h10C, 64'h80, 1'b0);
    issue(64'h10C, 64'h8000_1007, 64'd0, 1'b0, 1'b1, 3'b100);
    serve(64'h8012_3456_789A_BCDE, 0);
    check("lbu_wbdata", wb_if.wbdata_o, 64'h80);

    // A response coinciding with the request handshake must be ignored
    push_exp(64'h110, 64'h0123_4567_89AB_CDEF, 1'b0);
    issue(64'h110, 64'h200, 64'd0, 1'b0, 1'b1, 3'b011);
    mem_if.req_ready  = 1'b1;
    mem_if.resp_valid = 1'b1;
    mem_if.resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    mem_if.req_ready  = 1'b0;
    mem_if.resp_valid = 1'b0;
    check("early_resp_ignored", {63'd0, wb_if.out_valid}, 64'd0);
    @(negedge clk);
    check("early_resp_still_wait", {63'd0, wb_if.out_valid}, 64'd0);
    mem_if.resp_valid = 1'b1;
    mem_if.resp_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    mem_if.resp_valid = 1'b0;
    check("late_resp_out_valid", {63'd0, wb_if.out_valid}, 64'd1);

    add_vec(64'h1002, 3'b001, 1'b0, 1'b1, 64'd0, 64'h0000_0000_8001_0000);
    add_vec(64'h1006, 3'b101, 1'b0, 1'b1, 64'd0, 64'hBEEF_0000_0000_0000);
    add_vec(64'h1004, 3'b010, 1'b0, 1'b1, 64'd0, 64'h8765_4321_0000_0000);
    add_vec(64'h1000, 3'b110, 1'b0, 1'b1, 64'd0, 64'h0000_0000_F000_000F);
    add_vec(64'h1008, 3'b111, 1'b0, 1'b1, 64'd0, 64'hFEDC_BA98_7654_3210);
    add_vec(64'h1003, 3'b000, 1'b1, 1'b0, 64'h1122_3344_5566_77AB, 64'd0);
    add_vec(64'h1006, 3'b001, 1'b1, 1'b0, 64'h0000_0000_0000_CAFE, 64'd0);
    add_vec(64'h1010, 3'b011, 1'b1, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 64'h1234);
`ifndef MEM_MISALIGN_CHK_EN
    add_vec(64'h1016, 3'b010, 1'b0, 1'b1, 64'd0, 64'h8899_0000_0000_0000);
    add_vec(64'h1013, 3'b011, 1'b0, 1'b1, 64'd0, 64'hF1E2_D3C4_B5A6_9788);
    add_vec(64'h1016, 3'b010, 1'b1, 1'b0, 64'h7766_5544, 64'd0);
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t        v;
      logic [63:0] pc;
      v  = vecs[i];
      pc = 64'h200 + 64'(4 * i);
      push_exp(pc, v.wren ? 64'd0 : exp_load(v.rd, v.op, v.addr[2:0]), 1'b0);
      issue(pc, v.addr, v.rs2, v.wren, v.lden, v.op);
      check("vec_req_valid", {63'd0, mem_if.req_valid}, 64'd1);
      check("vec_req_addr", mem_if.req_addr, {v.addr[63:3], 3'b000});
      check("vec_req_wen", {63'd0, mem_if.req_wen}, {63'd0, v.wren});
      if (v.wren) begin
        check("vec_req_wmask", {56'd0, mem_if.req_wmask}, {56'd0, exp_mask(v.op, v.addr[2:0])});
        check("vec_req_wdata", mem_if.req_wdata, exp_wdata(v.rs2, v.addr[2:0]));
      end
      serve(v.rd, i % 3);
    end

`ifdef MEM_MISALIGN_CHK_EN
    push_exp(64'h180, 64'd0, 1'b1);
    issue(64'h180, 64'h8000_0002, 64'h1, 1'b0, 1'b1, 3'b010);
    check("mis_req_valid", {63'd0, mem_if.req_valid}, 64'd0);
    check("mis_out_valid", {63'd0, wb_if.out_valid}, 64'd1);
    check("mis_flag", {63'd0, wb_if.misalign_o}, 64'd1);
    check("mis_wbdata", wb_if.wbdata_o, 64'd0);
`endif

    // Asynchronous reset while waiting for a response abandons the access
    issue(64'h300, 64'h400, 64'd0, 1'b0, 1'b1, 3'b011);
    check("rw_req_valid", {63'd0, mem_if.req_valid}, 64'd1);
    mem_if.req_ready = 1'b1;
    @(negedge clk);
    mem_if.req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rw_req_valid_rst", {63'd0, mem_if.req_valid}, 64'd0);
    check("rw_in_ready_rst", {63'd0, ex_if.in_ready}, 64'd1);
    check("rw_pc_rst", wb_if.PC_mem_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_if.resp_valid = 1'b1;
    mem_if.resp_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_if.resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rw_no_out", {63'd0, wb_if.out_valid}, 64'd0);
      @(negedge clk);
    end

    push_exp(64'h400, 64'hABCD, 1'b0);
    issue(64'h400, 64'hABCD, 64'd0, 1'b0, 1'b0, 3'b000);
    check("post_rst_out_valid", {63'd0, wb_if.out_valid}, 64'd1);
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage consuming EX-stage outputs (PC, instr, ALU result as address, rs2 as store data, wren/lden, mem_op).
- Issues load/store requests to data memory over a valid/ready request channel plus a response channel.
- Aligns store data/mask, extracts and sign/zero-extends load data, and forwards the result to WB via a valid/ready handshake.
- Stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 64, datapath width (taken from the shared defines).
- BUS_W, 64, data bus width; must equal XLEN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  EX result valid
- in_ready  out  1  stage can accept EX result
- PC_mem_i, instr_mem_i  in  XLEN  passthrough
- alures_i  in  XLEN  ALU result / effective address
- rs2_mem_i  in  XLEN  store data
- mem_wren_i, mem_lden_i  in  1  store / load enable
- mem_op_i  in  3  funct3 size/sign code
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_addr  out  XLEN  8-byte-aligned address
- req_wen  out  1  1 = store
- req_wdata  out  BUS_W  lane-shifted store data
- req_wmask  out  BUS_W/8  byte strobes
- resp_valid  in  1  memory response
- resp_rdata  in  BUS_W  read data (stores: ignored)
- out_valid  out  1  result valid to WB
- out_ready  in  1  WB accepts
- PC_mem_o, instr_mem_o  out  XLEN  passthrough
- wbdata_o  out  XLEN  load data, or ALU result for non-memory instructions, or 0 for stores
- misalign_o  out  1  misaligned-access flag

Behaviour:
- Reset (async on rst_n low): state=IDLE; out_valid=0, req_valid=0, req_wen=0, misalign_o=0; all data outputs 0.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept on in_valid && in_ready in cycle T: latch all inputs.
- FSM IDLE/REQ/WAIT.
  - Non-memory instruction: stay IDLE; out_valid=1 at T+1, wbdata_o=alures.
  - Memory instruction: IDLE -> REQ; req_valid=1 from T+1, held stable until req_ready.
  - REQ & req_ready -> WAIT; req_valid drops the next cycle.
  - WAIT & resp_valid -> IDLE; out_valid=1 the next cycle with wbdata_o.
  - Minimum memory latency: result at T+3 with req_ready and resp_valid asserted in consecutive cycles.
- Response timing: a response in the same cycle as the req_ready handshake is not accepted; responses are only sampled in WAIT, and resp_valid is ignored in IDLE/REQ.
- out_valid and its data hold until out_ready; a new accept is possible in the same cycle as out_ready.
- mem_op sizes: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU; 111 treated as 011.
- Address: req_addr = {addr[XLEN-1:3],3'b0}; off = addr[2:0].
- Store: wmask = size_mask << off (B=0x01, H=0x03, W=0x0F, D=0xFF); wdata = rs2 << (8*off); wbdata_o = 0.
- Load: rdata >> (8*off), truncated to the size, then sign-extended (codes 000-011) or zero-extended (100-110).
- wren && lden both set: treated as store.
- Wrap-around: unaligned accesses crossing the 8-byte line are truncated to the line.

Optional Feature:
- Macro MEM_MISALIGN_CHK_EN.
- Defined: off not a multiple of the access size -> no bus request; stay IDLE; out_valid at T+1 with misalign_o=1, wbdata_o=0.
- Undefined: no check; misalign_o tied 0; the truncation rule applies.

Decomposition:
- Shared defines header holds XLEN, mem_op encodings, and FSM state encodings.
- One combinational sub-module, mem_align: store lane/mask generation and load extract/extension. The FSM and pipeline registers stay in mem_stage.

Test Plan:
- Non-memory op, alures=0x1234 -> out_valid at T+1, wbdata_o=0x1234, req_valid never asserts.
- SW addr=0x8000_0004, rs2=0xDEADBEEF -> req_addr=0x8000_0000, wmask=0xF0, wdata=0xDEADBEEF_00000000, req_wen=1; out_valid one cycle after resp_valid.
- LB addr=0x...07, rdata=0x80xx_xxxx_xxxx_xxxx -> wbdata_o=0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80.
- Backpressure: req_ready low 3 cycles, then out_ready low 2 cycles -> req fields stable, in_ready=0 throughout, output data held.
- rst_n pulsed low in WAIT -> immediate IDLE, req_valid=0; a later resp_valid is ignored, out_valid stays 0.
- With MEM_MISALIGN_CHK_EN: LW addr=0x...02 -> no req_valid, out_valid at T+1, misalign_o=1, wbdata_o=0.
